uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_fifo.sv | 75 +++++++
 rtl/uart_tx_feeder.sv | 118 +++++++++++
 tb/tb_uart_tx_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and sender FSM encoding for the UART TX feeder
package uart_pkg;

   localparam int BYTE_W        = 8;
   localparam int DEPTH_DEFAULT = 16;

   localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;
   localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - byte FIFO with registered ready, occupancy level and sticky overflow
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [BYTE_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic              pop_i,
   output logic [BYTE_W-1:0] head_o,
   output logic [ADDR_W:0]   level_o,
   output logic              empty_o,
   output logic              overflow_o
);

   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              wr_ready_q, wr_ready_d;
   logic              overflow_q, overflow_d;
   logic              push;
   logic              pop;

   always_comb begin
      push       = wr_valid_i & wr_ready_q;
      pop        = pop_i & (level_q != '0);
      wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      level_d    = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
         2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
         default: level_d = level_q;
      endcase
      // Ready is registered, so it is computed from the post-update level.
      wr_ready_d = (level_d != FULL_LEVEL);
      overflow_d = overflow_q | (wr_valid_i & ~wr_ready_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wr_ready_q <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         wr_ready_q <= wr_ready_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign head_o     = mem_q[rd_ptr_q];
   assign level_o    = level_q;
   assign empty_o    = (level_q == '0);
   assign wr_ready_o = wr_ready_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - drains a byte FIFO into a UART transmitter via a SEND/READY handshake
// Optional LF -> CR,LF expansion when UART_TX_FEEDER_CRLF_EN is defined.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [BYTE_W-1:0] WR_DATA,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic              TX_READY,
   output logic              TX_SEND,
   output logic [BYTE_W-1:0] TX_DATA,
   output logic [ADDR_W:0]   LEVEL,
   output logic              EMPTY,
   output logic              OVERFLOW
);

   tx_state_e         state_q, state_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic [BYTE_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              pop;
   logic              tx_send;
`ifdef UART_TX_FEEDER_CRLF_EN
   logic              cr_done_q, cr_done_d;
`endif

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .wr_data_i  (WR_DATA),
      .wr_valid_i (WR_VALID),
      .wr_ready_o (WR_READY),
      .pop_i      (pop),
      .head_o     (fifo_head),
      .level_o    (LEVEL),
      .empty_o    (fifo_empty),
      .overflow_o (OVERFLOW)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      tx_send   = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
      cr_done_d = cr_done_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && TX_READY) begin
               state_d = ST_SEND;
`ifdef UART_TX_FEEDER_CRLF_EN
               // An LF head goes out twice: first as CR (kept queued), then itself.
               if (fifo_head == CHAR_LF && !cr_done_q) begin
                  tx_data_d = CHAR_CR;
                  cr_done_d = 1'b1;
               end else begin
                  tx_data_d = fifo_head;
                  pop       = 1'b1;
                  cr_done_d = 1'b0;
               end
`else
               tx_data_d = fifo_head;
               pop       = 1'b1;
`endif
            end
         end
         ST_SEND: begin
            tx_send = 1'b1;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!TX_READY) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (TX_READY) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
   end

`ifdef UART_TX_FEEDER_CRLF_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cr_done_q <= 1'b0;
      end else begin
         cr_done_q <= cr_done_d;
      end
   end
`endif

   assign TX_SEND = tx_send;
   assign TX_DATA = tx_data_q;
   assign EMPTY   = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed bench for uart_tx_feeder with a 10-cycles-per-bit UART model
// Covers the UART_TX_FEEDER_CRLF_EN build as well as the default build.
module tb_uart_tx_feeder;

   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int UART_LEN = 100;

   logic              clk;
   logic              rst_n;
   logic [7:0]        wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              tx_ready;
   logic              tx_send;
   logic [7:0]        tx_data;
   logic [ADDR_W:0]   level;
   logic              empty;
   logic              overflow;

   logic              hold;
   int                busy_cnt;
   int                viol;
   logic [7:0]        sd_q [$];
   logic [ADDR_W:0]   sl_q [$];
   logic [7:0]        exp_q [$];

   int                errors;
   int                checks;

   uart_tx_feeder #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .WR_DATA  (wr_data),
      .WR_VALID (wr_valid),
      .WR_READY (wr_ready),
      .TX_READY (tx_ready),
      .TX_SEND  (tx_send),
      .TX_DATA  (tx_data),
      .LEVEL    (level),
      .EMPTY    (empty),
      .OVERFLOW (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_ready = !hold && (busy_cnt == 0);

   // UART model and strobe monitor; it is not reset by RST_N.
   always @(negedge clk) begin
      if (tx_send) begin
         if (busy_cnt != 0) viol++;
         sd_q.push_back(tx_data);
         sl_q.push_back(level);
         busy_cnt = UART_LEN;
      end else if (busy_cnt != 0) begin
         busy_cnt--;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobes(input int n, input int budget, input string tag);
      int cyc = 0;
      while (sd_q.size() < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(sd_q.size() >= n), 32'd1);
   endtask

   task automatic wait_uart_idle(input string tag);
      int cyc = 0;
      while (busy_cnt != 0 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(busy_cnt), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic order_check(input string tag);
      int bad = 0;
      int n   = (sd_q.size() < exp_q.size()) ? sd_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (sd_q[i] !== exp_q[i]) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      viol     = 0;
      busy_cnt = 0;
      hold     = 1'b0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      repeat (2) @(negedge clk);

      check("rst_empty",    32'(empty),    32'd1);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_tx_send",  32'(tx_send),  32'd0);
      check("rst_tx_data",  32'(tx_data),  32'h00);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_level",    32'(level),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two bytes, each strobe only once the UART is idle again
      @(negedge clk); wr_valid = 1'b1; wr_data = 8'h41;
      @(negedge clk); wr_data = 8'h42;
      @(negedge clk); wr_valid = 1'b0;
      wait_strobes(2, 400, "a_timeout");
      wait_uart_idle("a_idle_timeout");
      check("a_count", 32'(sd_q.size()), 32'd2);
      check("a_data0", 32'(sd_q[0]),     32'h41);
      check("a_data1", 32'(sd_q[1]),     32'h42);
      check("a_viol",  32'(viol),        32'd0);

      // Fill past full with the UART held busy
      sd_q.delete(); sl_q.delete(); exp_q.delete();
      hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk); wr_valid = 1'b1; wr_data = 8'(8'h50 + i);
         if (i < 16) exp_q.push_back(8'(8'h50 + i));
      end
      @(negedge clk); wr_valid = 1'b0;
      check("b_wr_ready", 32'(wr_ready),     32'd0);
      check("b_level",    32'(level),        32'd16);
      check("b_overflow", 32'(overflow),     32'd1);
      check("b_nosend",   32'(sd_q.size()),  32'd0);
      hold = 1'b0;
      wait_strobes(16, 2200, "b_timeout");
      repeat (300) @(negedge clk);
      check("b_count", 32'(sd_q.size()), 32'd16);
      order_check("b_order");
      check("b_empty", 32'(empty), 32'd1);
      rst_n = 1'b0;
      #1;
      check("b_rst_overflow", 32'(overflow), 32'd0);
      check("b_rst_wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // 40 bytes through a 16-deep FIFO: pointers wrap twice
      sd_q.delete(); sl_q.delete(); exp_q.delete();
      for (int i = 0; i < 40; i++) begin
`ifdef UART_TX_FEEDER_CRLF_EN
         if (i == 10) exp_q.push_back(8'h0D);
`endif
         exp_q.push_back(8'(i));
      end
      begin
         int idx = 0;
         int cyc = 0;
         while (idx < 40 && cyc < 6000) begin
            @(negedge clk);
            if (wr_ready) begin
               wr_valid = 1'b1;
               wr_data  = 8'(idx);
               idx++;
            end else begin
               wr_valid = 1'b0;
            end
            cyc++;
         end
         @(negedge clk); wr_valid = 1'b0;
         check("c_fill", 32'(idx), 32'd40);
      end
      wait_strobes(exp_q.size(), 6000, "c_timeout");
      wait_uart_idle("c_idle_timeout");
      check("c_count", 32'(sd_q.size()), 32'(exp_q.size()));
      order_check("c_order");
      check("c_empty",    32'(empty),    32'd1);
      check("c_level",    32'(level),    32'd0);
      check("c_overflow", 32'(overflow), 32'd0);
      check("c_viol",     32'(viol),     32'd0);

      // Reset in WAIT_DONE with five bytes still queued
      sd_q.delete(); sl_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); wr_valid = 1'b1; wr_data = 8'(8'h70 + i);
      end
      @(negedge clk); wr_valid = 1'b0;
      wait_strobes(1, 50, "d_timeout");
      repeat (10) @(negedge clk);
      check("d_level_pre", 32'(level), 32'd5);
      rst_n = 1'b0;
      #1;
      check("d_rst_level",   32'(level),   32'd0);
      check("d_rst_tx_send", 32'(tx_send), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("d_count", 32'(sd_q.size()), 32'd1);
      check("d_data0", 32'(sd_q[0]),     32'h70);
      check("d_level", 32'(level),       32'd0);
      check("d_empty", 32'(empty),       32'd1);

      // Line-feed handling
      sd_q.delete(); sl_q.delete();
      @(negedge clk); wr_valid = 1'b1; wr_data = 8'h0A;
      @(negedge clk); wr_valid = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
      wait_strobes(2, 400, "e_timeout");
      repeat (300) @(negedge clk);
      check("e_count",  32'(sd_q.size()), 32'd2);
      check("e_data0",  32'(sd_q[0]),     32'h0D);
      check("e_data1",  32'(sd_q[1]),     32'h0A);
      check("e_level0", 32'(sl_q[0]),     32'd1);
      check("e_level1", 32'(sl_q[1]),     32'd0);
`else
      wait_strobes(1, 400, "e_timeout");
      repeat (300) @(negedge clk);
      check("e_count",  32'(sd_q.size()), 32'd1);
      check("e_data0",  32'(sd_q[0]),     32'h0A);
      check("e_level0", 32'(sl_q[0]),     32'd0);
`endif
      check("e_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
